// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared types and encodings for the memory-stage load/store unit
package mem_stage_lsu_pkg;
  typedef enum logic {IDLE, REQ} lsu_state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_data;
  } mem_wb_t;
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane/enable generation, load extract/extend and access fault detection
module lsu_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        fault,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  // Store side: size comes from funct3[1:0]; faults cover illegal sizes and misalignment
  always_comb begin
    be = funct3[1:0] == F3_SB[1:0] ? 4'b0001 << off :
         funct3[1:0] == F3_SH[1:0] ? 4'b0011 << off : 4'b1111;
    wdata = funct3[1:0] == F3_SB[1:0] ? {4{wd[7:0]}} :
            funct3[1:0] == F3_SH[1:0] ? {2{wd[15:0]}} : wd;
    fault = funct3 == 3'b011 || funct3[2:1] == 2'b11 ||
            (funct3[1:0] == F3_SW[1:0] && off != 2'b00) ||
            (funct3[1:0] == F3_SH[1:0] && off[0]);
  end
  // Load side: pick the addressed byte/half and extend by the signedness bit
  always_comb begin
    ld_byte = rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_data = ld_funct3 == F3_LB  ? {{24{ld_byte[7]}}, ld_byte} :
              ld_funct3 == F3_LBU ? {24'b0, ld_byte} :
              ld_funct3 == F3_LH  ? {{16{ld_half[15]}}, ld_half} :
              ld_funct3 == F3_LHU ? {16'b0, ld_half} : rdata;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit with req/ack data memory port and MEM/WB register
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic        reg_write_m,
  input  logic [4:0]  rd_m,
  input  logic [1:0]  wb_sel_m,
  input  logic [31:0] DataMemoryAddress_m,
  input  logic [31:0] WD_m,
  input  logic [31:0] PC4_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        err_m,
  output logic        valid_w,
  output logic        reg_write_w,
  output logic [4:0]  rd_w,
  output logic [31:0] wb_data_w
);
  localparam int CW = $clog2(ACK_TIMEOUT);
  lsu_state_t  state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] req_addr, req_wdata, wdata, ld_data;
  logic [3:0]  req_be, be;
  logic [2:0]  req_f3;
  logic [1:0]  req_off;
  logic [4:0]  req_rd;
  logic        req_we, req_rw, fault, mem_op, start, bad, timeout;
  mem_wb_t     wb, wb_nx;
  lsu_lane_align u_align (
    .funct3(funct3_m),
    .off(DataMemoryAddress_m[1:0]),
    .wd(WD_m),
    .be(be),
    .wdata(wdata),
    .fault(fault),
    .ld_funct3(req_f3),
    .ld_off(req_off),
    .rdata(dmem_rdata),
    .ld_data(ld_data)
  );
  // Decide whether the slot starts, faults or finishes a transaction; ack beats timeout
  always_comb begin
    mem_op = valid_m && (mem_read_m || mem_write_m);
    start = state == IDLE && mem_op && !fault;
    bad = state == IDLE && mem_op && fault;
    timeout = state == REQ && !dmem_ack && cnt == CW'(ACK_TIMEOUT - 1);
    state_nx = state == IDLE ? (start ? REQ : IDLE) : (dmem_ack || timeout ? IDLE : REQ);
    stall_m = !reset && (start || (state == REQ && !dmem_ack && !timeout));
    err_m = !reset && (bad || timeout);
  end
  // Next MEM/WB bundle: ALU/PC+4 ops retire from IDLE, memory ops on ack, else a bubble
  always_comb begin
    wb_nx = '0;
    if (state == IDLE && valid_m && !mem_op) begin
      wb_nx.valid = 1'b1;
      wb_nx.reg_write = reg_write_m && rd_m != 5'd0;
      wb_nx.rd = rd_m;
      wb_nx.wb_data = wb_sel_m == WB_PC4 ? PC4_m : DataMemoryAddress_m;
    end else if (state == REQ && dmem_ack) begin
      wb_nx.valid = 1'b1;
      wb_nx.reg_write = !req_we && req_rw && req_rd != 5'd0;
      wb_nx.rd = req_rd;
      wb_nx.wb_data = req_we ? 32'd0 : ld_data;
    end
  end
  // State, timeout counter, request registers and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      req_addr <= '0;
      req_wdata <= '0;
      req_be <= '0;
      req_we <= 1'b0;
      req_f3 <= '0;
      req_off <= '0;
      req_rd <= '0;
      req_rw <= 1'b0;
      wb <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == REQ && state_nx == REQ ? cnt + 1'b1 : '0;
      wb <= wb_nx;
      if (start) begin
        req_addr <= word_addr(DataMemoryAddress_m);
        req_wdata <= wdata;
        req_be <= mem_write_m ? be : 4'b0000;
        req_we <= mem_write_m;
        req_f3 <= funct3_m;
        req_off <= DataMemoryAddress_m[1:0];
        req_rd <= rd_m;
        req_rw <= reg_write_m;
      end
    end
  end
  assign dmem_req = state == REQ;
  assign dmem_we = req_we;
  assign dmem_addr = req_addr;
  assign dmem_wdata = req_wdata;
  assign dmem_be = req_be;
  assign valid_w = wb.valid;
  assign reg_write_w = wb.reg_write;
  assign rd_w = wb.rd;
  assign wb_data_w = wb.wb_data;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized self-checking bench against a transaction-level LSU model
module tb_mem_stage_lsu;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic reset, valid_m, mem_read_m, mem_write_m, reg_write_m, dmem_ack;
  logic [2:0] funct3_m;
  logic [4:0] rd_m;
  logic [1:0] wb_sel_m;
  logic [31:0] DataMemoryAddress_m, WD_m, PC4_m, dmem_rdata;
  logic dmem_req, dmem_we, stall_m, err_m, valid_w, reg_write_w;
  logic [31:0] dmem_addr, dmem_wdata, wb_data_w;
  logic [3:0] dmem_be;
  logic [4:0] rd_w;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .funct3_m(funct3_m), .reg_write_m(reg_write_m),
    .rd_m(rd_m), .wb_sel_m(wb_sel_m), .DataMemoryAddress_m(DataMemoryAddress_m),
    .WD_m(WD_m), .PC4_m(PC4_m), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_m(stall_m), .err_m(err_m),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w), .wb_data_w(wb_data_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_fault(input logic [2:0] f3, input logic [31:0] a);
    int nb = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int nb = 1 << f3[1:0];
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int nb = 1 << f3[1:0];
    return nb == 1 ? wd[7:0] * 32'h01010101 : nb == 2 ? wd[15:0] * 32'h00010001 : wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    longint nb = longint'(1) << f3[1:0];
    longint range = longint'(1) << (8 * nb);
    longint raw = (longint'(rdata) >> (8 * (a % 4))) % range;
    if (!f3[2] && nb < 4 && raw >= range / 2) raw = raw - range;
    return 32'(raw);
  endfunction

  task automatic run_instr(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                           input logic rw, input logic [4:0] rd, input logic [1:0] ws,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc4,
                           input logic [31:0] rdata, input int k, input bit dchk, input logic [31:0] dwant);
    logic mem, flt, legal, acked, ev;
    valid_m = v; mem_read_m = mr; mem_write_m = mw; funct3_m = f3; reg_write_m = rw;
    rd_m = rd; wb_sel_m = ws; DataMemoryAddress_m = a; WD_m = wd; PC4_m = pc4;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    mem = v && (mr || mw);
    flt = mem && is_fault(f3, a);
    legal = mem && !flt;
    acked = 1'b0;
    @(negedge clk);
    check("c0_stall", stall_m, legal);
    check("c0_err", err_m, flt);
    check("c0_req", dmem_req, 0);
    check("c0_valid_w", valid_w, 0);
    if (legal) begin
      for (int i = 1; i <= TO; i++) begin
        @(posedge clk); #1;
        dmem_ack = i == k;
        dmem_rdata = i == k ? rdata : $urandom;
        @(negedge clk);
        check("req", dmem_req, 1);
        check("we", dmem_we, mw);
        check("addr", dmem_addr, a - a % 4);
        check("be", dmem_be, mw ? exp_be(f3, a) : 4'b0000);
        if (mw) check("wdata", dmem_wdata, exp_wdata(f3, wd));
        check("req_stall", stall_m, i != k && i != TO);
        check("req_err", err_m, i == TO && i != k);
        check("req_valid_w", valid_w, 0);
        if (i == k) begin
          acked = 1'b1;
          break;
        end
      end
    end
    @(posedge clk); #1;
    valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    ev = v && (!mem || acked);
    check("wb_req", dmem_req, 0);
    check("wb_stall", stall_m, 0);
    check("wb_err", err_m, 0);
    check("valid_w", valid_w, ev);
    check("reg_write_w", reg_write_w, ev && !mw && rw && rd != 5'd0);
    if (ev) check("rd_w", rd_w, rd);
    if (ev && !mw) check("wb_data", wb_data_w, mem ? exp_load(f3, a, rdata) : ws == 2'b10 ? pc4 : a);
    if (dchk) check("directed_wb", wb_data_w, dwant);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset = 1'b1; valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = 3'b010;
    reg_write_m = 1'b1; rd_m = 5'd1; wb_sel_m = 2'b01; DataMemoryAddress_m = 32'h100;
    WD_m = 32'h0; PC4_m = 32'h4; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall_m, 0);
    check("rst_err", err_m, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_be", dmem_be, 0);
    check("rst_valid_w", valid_w, 0);
    check("rst_reg_write_w", reg_write_w, 0);
    check("rst_rd_w", rd_w, 0);
    check("rst_wb_data", wb_data_w, 0);
    @(posedge clk); #1;
    reset = 1'b0; valid_m = 1'b0; mem_read_m = 1'b0;
    @(posedge clk); #1;
    run_instr(1, 0, 0, 3'b000, 1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h8, 32'h0, 1, 1, 32'h00001234);
    run_instr(1, 0, 0, 3'b000, 1, 5'd6, 2'b10, 32'h1234, 32'h0, 32'h88, 32'h0, 1, 1, 32'h00000088);
    run_instr(1, 0, 1, 3'b000, 0, 5'd0, 2'b00, 32'h1003, 32'hAABBCCDD, 32'h0, 32'h0, 3, 0, 0);
    run_instr(1, 1, 0, 3'b000, 1, 5'd7, 2'b01, 32'h2002, 32'h0, 32'h0, 32'h0080FF00, 1, 1, 32'hFFFFFF80);
    run_instr(1, 1, 0, 3'b100, 1, 5'd7, 2'b01, 32'h2002, 32'h0, 32'h0, 32'h0080FF00, 1, 1, 32'h00000080);
    run_instr(1, 1, 0, 3'b000, 1, 5'd8, 2'b01, 32'h2001, 32'h0, 32'h0, 32'h0080FF00, 1, 1, 32'hFFFFFFFF);
    run_instr(1, 1, 0, 3'b101, 1, 5'd8, 2'b01, 32'h2002, 32'h0, 32'h0, 32'h0080FF00, 1, 1, 32'h00000080);
    run_instr(1, 1, 0, 3'b010, 1, 5'd9, 2'b01, 32'h3002, 32'h0, 32'h0, 32'h12345678, 1, 0, 0);
    run_instr(1, 1, 0, 3'b010, 1, 5'd9, 2'b01, 32'h4000, 32'h0, 32'h0, 32'h12345678, 0, 0, 0);
    run_instr(1, 1, 0, 3'b010, 1, 5'd0, 2'b01, 32'h4000, 32'h0, 32'h0, 32'h12345678, 2, 0, 0);
    valid_m = 1'b1; mem_read_m = 1'b1; funct3_m = 3'b010; DataMemoryAddress_m = 32'h5000;
    rd_m = 5'd3; reg_write_m = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    check("mid_c0_stall", stall_m, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_req1", dmem_req, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_stall", stall_m, 0);
    check("mid_rst_err", err_m, 0);
    @(posedge clk); #1;
    reset = 1'b0; valid_m = 1'b0; mem_read_m = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("mid_req_low", dmem_req, 0);
    check("mid_addr", dmem_addr, 0);
    check("mid_be", dmem_be, 0);
    check("mid_valid_w", valid_w, 0);
    check("mid_wb_data", wb_data_w, 0);
    check("late_ack_stall", stall_m, 0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_valid_w", valid_w, 0);
    check("late_ack_reg_write", reg_write_w, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(0, 9);
      logic [2:0] f3 = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      logic [31:0] a = $urandom;
      int k = $urandom_range(0, 29) == 0 ? 0 : $urandom_range(1, 4);
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_instr(kind != 0, kind >= 4 && kind <= 6 || (kind == 0 && $urandom_range(0, 1) == 1), kind >= 7,
                f3, 1'($urandom), 5'($urandom), 2'($urandom), a, $urandom, $urandom, $urandom, k, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
